// File: rtl/issue_queue_multiport.sv
// Parametrised circular issue queue between decode and issue: up to PUSH_W entries in
// and POP_W entries out per cycle, all-or-nothing push, clamped pop, flush, sticky errors.
module issue_queue_multiport #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 16,
    parameter  int PUSH_W = 2,
    parameter  int POP_W  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PN_W   = $clog2(PUSH_W + 1),
    localparam int QN_W   = $clog2(POP_W + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [PN_W-1:0]           in_data_number,
    input  logic [PUSH_W*DATA_W-1:0]  in_data,
    input  logic [QN_W-1:0]           out_data_number,
    output logic [POP_W*DATA_W-1:0]   out_data,
    output logic [POP_W-1:0]          out_valid,
    output logic [CNT_W-1:0]          size,
    output logic [CNT_W-1:0]          size_left,
    output logic                      push_ovf,
    output logic                      pop_udf
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < PUSH_W) || (DEPTH < POP_W)) begin : g_bad_depth
        $error("issue_queue_multiport: DEPTH must be a power of two >= max(PUSH_W, POP_W)");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  pop_req;
    logic [CNT_W-1:0]  pop_eff;
    logic [CNT_W-1:0]  push_req;
    logic [CNT_W-1:0]  push_eff;
    logic              pop_bad;
    logic              push_bad;

    assign size      = count;
    assign size_left = CNT_W'(DEPTH) - count;

    // Push is judged against the pre-cycle free space, so a same-cycle pop never makes room.
    always_comb begin
        pop_req  = CNT_W'(out_data_number);
        pop_eff  = pop_req;
        if (pop_eff > count) pop_eff = count;
        if (pop_eff > CNT_W'(POP_W)) pop_eff = CNT_W'(POP_W);
        pop_bad  = (pop_req > count) || (pop_req > CNT_W'(POP_W));
        push_req = CNT_W'(in_data_number);
        push_bad = (push_req > size_left) || (push_req > CNT_W'(PUSH_W));
        push_eff = push_bad ? '0 : push_req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            push_ovf <= 1'b0;
            pop_udf  <= 1'b0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_eff);
            tail  <= tail + PTR_W'(push_eff);
            count <= count + push_eff - pop_eff;
            if (push_bad) push_ovf <= 1'b1;
            if (pop_bad)  pop_udf  <= 1'b1;
        end
    end

    // Storage is not reset; lanes beyond the occupied count are masked at the output.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int unsigned j = 0; j < PUSH_W; j++) begin
                if (CNT_W'(j) < push_eff)
                    mem[tail + PTR_W'(j)] <= in_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        out_data  = '0;
        out_valid = '0;
        for (int unsigned i = 0; i < POP_W; i++) begin
            out_valid[i] = CNT_W'(i) < count;
            if (out_valid[i])
                out_data[i*DATA_W +: DATA_W] = mem[head + PTR_W'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) assert (count <= CNT_W'(DEPTH));
    end

endmodule
